vt_console: RTL
===============

# vt_console

Parametrised text-terminal write engine between the host byte stream and the character VRAM. It interprets printable bytes and the basic control characters CR, LF, BS and TAB, and tracks the cursor and scroll origin. It clears VRAM after reset and clears each newly exposed row on scroll. The video side reads `top_row` as a circular scroll origin. The cursor outputs drive the cursor overlay.

## Interface
- `ROW_BITS`, 5: VRAM row address width; VRAM holds 2^ROW_BITS rows, used circularly.
- `COL_BITS`, 7: column address width.
- `ROWS`, 30: visible rows; must be < 2^ROW_BITS.
- `COLS`, 100: columns per row; must be ≤ 2^COL_BITS.
- `TAB_WIDTH`, 8: tab stop spacing; must be a power of two.
- `FILL_BYTE`, 8'h20: byte written by clears.
- `clk`  in  1  system clock.
- `reset_low`  in  1  asynchronous, active-low reset.
- `host_ready`  out  1  byte accepted this cycle when high with `host_valid`.
- `host_valid`  in  1  `host_byte` valid.
- `host_byte`  in  8  character or control byte.
- `vram_ready`  in  1  VRAM write accepted this cycle.
- `vram_valid`  out  1  write request.
- `vram_row`  out  ROW_BITS  write row.
- `vram_col`  out  COL_BITS  write column.
- `vram_byte`  out  8  write data.
- `top_row`  out  ROW_BITS  VRAM row shown on the first screen line.
- `cursor_row`  out  ROW_BITS  cursor VRAM row.
- `cursor_col`  out  COL_BITS  cursor column.

## Operation
- States: INIT (clear all VRAM), IDLE (service host), SCROLL (clear one row).
- Reset values: state INIT, `top_row`=0, internal `bottom_row`=ROWS-1, `cursor_row`=0, `cursor_col`=0, clear row/col counters 0.
- While `reset_low` is low, `host_ready` and `vram_valid` are forced to 0.
- INIT
  - Drives `vram_valid`=1, `vram_byte`=FILL_BYTE at the clear row/col counters.
  - Each handshake advances the column; after COLS-1 the column returns to 0 and the row advances.
  - After the write to row 2^ROW_BITS-1, column COLS-1, the state becomes IDLE.
  - `host_ready`=0.
- IDLE, printable byte (0x20–0x7E)
  - Combinationally drives `vram_valid`=`host_valid`, `vram_row/col`=cursor, `vram_byte`=`host_byte`, `host_ready`=`vram_ready`.
  - On handshake: if `cursor_col`<COLS-1, `cursor_col`+1. Otherwise `cursor_col`←0 and a newline is performed.
- IDLE, control byte (0x00–0x1F, 0x7F)
  - Drives `vram_valid`=0 and `host_ready`=1, consumed in one cycle.
  - LF 0x0A: newline.
  - CR 0x0D: `cursor_col`←0.
  - BS 0x08: `cursor_col`−1 if nonzero, else unchanged.
  - TAB 0x09: `cursor_col`←next multiple of TAB_WIDTH strictly above the current column, clamped to COLS-1.
  - All other control bytes are ignored.
- Newline
  - `cursor_row`+1 modulo 2^ROW_BITS.
  - If `cursor_row`==`bottom_row` before the step: `top_row`+1 and `bottom_row`+1 (both modulo 2^ROW_BITS). The clear row is loaded with the new cursor row, the clear column with 0, and the state becomes SCROLL.
- SCROLL
  - Same write pattern as INIT, restricted to the clear row.
  - Returns to IDLE after the handshake at column COLS-1.
  - `host_ready`=0.
- All row arithmetic wraps at 2^ROW_BITS; column arithmetic never exceeds COLS-1.

## Timing
- Printable byte: 0 added latency. Host and VRAM handshakes occur in the same cycle; the cursor updates at that clock edge.
- Control byte: accepted in 1 cycle regardless of `vram_ready`; the cursor updates at that edge.
- SCROLL entered at the edge of the wrapping or LF handshake. With `vram_ready` held at 1, `host_ready` returns high exactly COLS cycles later.
- INIT with `vram_ready` held at 1 takes 2^ROW_BITS×COLS cycles after reset release.
- `vram_ready` low stalls INIT and SCROLL with row, column and byte held stable.
- Reset mid-INIT or mid-SCROLL: all state returns to reset values immediately; INIT restarts from row 0, column 0 after release.
- `top_row` and cursor outputs are registered and never glitch.

## Test plan
- Reset release with `vram_ready`=1 → 3200 writes of 0x20 covering rows 0–31 × cols 0–99 in order, then `host_ready` rises.
- After init, send "AB" → writes (0,0,'A') and (0,1,'B'); cursor becomes (0,2).
- At (0,13), send TAB, BS, CR → `cursor_col`=16, then 15, then 0; no VRAM writes; one cycle per byte.
- At (29,99), send 'Z' → write (29,99,'Z'); cursor (30,0); `top_row`=1; 100 writes of 0x20 to row 30. Then LF from row 30 with `top_row`=1 → row 31 cleared, `top_row`=2.
- Toggle `vram_ready` low for 3 cycles during SCROLL and during a printable byte → request held stable, no cursor movement, no duplicate writes.
- Assert `reset_low` low at SCROLL column 50 → outputs return to reset values that cycle; INIT restarts at (0,0) after release.

Source files
------------

// File: rtl/vt_console.sv
// Text-terminal write engine: interprets host bytes, clears VRAM on init/scroll, tracks cursor and scroll origin.
// Printable bytes pass straight through to VRAM (0 latency, host stalls on vram_ready); control bytes take 1 cycle; host is held off while clearing.
module vt_console #(
    parameter int         ROW_BITS  = 5,
    parameter int         COL_BITS  = 7,
    parameter int         ROWS      = 30,
    parameter int         COLS      = 100,
    parameter int         TAB_WIDTH = 8,
    parameter logic [7:0] FILL_BYTE = 8'h20
) (
    input  logic                clk,
    input  logic                reset_low,
    output logic                host_ready,
    input  logic                host_valid,
    input  logic [7:0]          host_byte,
    input  logic                vram_ready,
    output logic                vram_valid,
    output logic [ROW_BITS-1:0] vram_row,
    output logic [COL_BITS-1:0] vram_col,
    output logic [7:0]          vram_byte,
    output logic [ROW_BITS-1:0] top_row,
    output logic [ROW_BITS-1:0] cursor_row,
    output logic [COL_BITS-1:0] cursor_col
);

    localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(COLS - 1);
    localparam logic [ROW_BITS-1:0] LAST_ROW = '1;
    localparam logic [ROW_BITS-1:0] BOT_RST  = ROW_BITS'(ROWS - 1);
    localparam logic [COL_BITS-1:0] TAB_MASK = COL_BITS'(TAB_WIDTH - 1);

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_SCROLL} state_t;

    state_t              state_q, state_d;
    logic [ROW_BITS-1:0] top_q, top_d;
    logic [ROW_BITS-1:0] bottom_q, bottom_d;
    logic [ROW_BITS-1:0] cur_row_q, cur_row_d;
    logic [COL_BITS-1:0] cur_col_q, cur_col_d;
    logic [ROW_BITS-1:0] clr_row_q, clr_row_d;
    logic [COL_BITS-1:0] clr_col_q, clr_col_d;

    logic                host_ready_c;
    logic                vram_valid_c;
    logic                printable;
    logic                do_nl;
    logic [COL_BITS:0]   tab_next;

    assign printable = (host_byte >= 8'h20) && (host_byte <= 8'h7E);
    // Next tab stop strictly above the cursor; one extra bit so the clamp sees overflow.
    assign tab_next  = {1'b0, cur_col_q | TAB_MASK} + (COL_BITS+1)'(1);

    always_comb begin
        state_d      = state_q;
        top_d        = top_q;
        bottom_d     = bottom_q;
        cur_row_d    = cur_row_q;
        cur_col_d    = cur_col_q;
        clr_row_d    = clr_row_q;
        clr_col_d    = clr_col_q;
        host_ready_c = 1'b0;
        vram_valid_c = 1'b0;
        vram_row     = clr_row_q;
        vram_col     = clr_col_q;
        vram_byte    = FILL_BYTE;
        do_nl        = 1'b0;

        case (state_q)
            ST_INIT: begin
                vram_valid_c = 1'b1;
                if (vram_ready) begin
                    if (clr_col_q == LAST_COL) begin
                        clr_col_d = '0;
                        clr_row_d = clr_row_q + ROW_BITS'(1);
                        if (clr_row_q == LAST_ROW)
                            state_d = ST_IDLE;
                    end else begin
                        clr_col_d = clr_col_q + COL_BITS'(1);
                    end
                end
            end
            ST_SCROLL: begin
                vram_valid_c = 1'b1;
                if (vram_ready) begin
                    if (clr_col_q == LAST_COL) begin
                        clr_col_d = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        clr_col_d = clr_col_q + COL_BITS'(1);
                    end
                end
            end
            default: begin
                if (printable) begin
                    vram_valid_c = host_valid;
                    vram_row     = cur_row_q;
                    vram_col     = cur_col_q;
                    vram_byte    = host_byte;
                    host_ready_c = vram_ready;
                    if (host_valid && vram_ready) begin
                        if (cur_col_q < LAST_COL) begin
                            cur_col_d = cur_col_q + COL_BITS'(1);
                        end else begin
                            cur_col_d = '0;
                            do_nl     = 1'b1;
                        end
                    end
                end else begin
                    host_ready_c = 1'b1;
                    if (host_valid) begin
                        case (host_byte)
                            8'h0A: do_nl = 1'b1;
                            8'h0D: cur_col_d = '0;
                            8'h08: if (cur_col_q != '0) cur_col_d = cur_col_q - COL_BITS'(1);
                            8'h09: cur_col_d = (tab_next > {1'b0, LAST_COL}) ? LAST_COL
                                                                             : tab_next[COL_BITS-1:0];
                            default: ;
                        endcase
                    end
                end
            end
        endcase

        // A newline off the bottom visible row scrolls and blanks the newly exposed row.
        if (do_nl) begin
            cur_row_d = cur_row_q + ROW_BITS'(1);
            if (cur_row_q == bottom_q) begin
                top_d     = top_q + ROW_BITS'(1);
                bottom_d  = bottom_q + ROW_BITS'(1);
                clr_row_d = cur_row_q + ROW_BITS'(1);
                clr_col_d = '0;
                state_d   = ST_SCROLL;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            state_q   <= ST_INIT;
            top_q     <= '0;
            bottom_q  <= BOT_RST;
            cur_row_q <= '0;
            cur_col_q <= '0;
            clr_row_q <= '0;
            clr_col_q <= '0;
        end else begin
            state_q   <= state_d;
            top_q     <= top_d;
            bottom_q  <= bottom_d;
            cur_row_q <= cur_row_d;
            cur_col_q <= cur_col_d;
            clr_row_q <= clr_row_d;
            clr_col_q <= clr_col_d;
        end
    end

    assign host_ready = host_ready_c & reset_low;
    assign vram_valid = vram_valid_c & reset_low;
    assign top_row    = top_q;
    assign cursor_row = cur_row_q;
    assign cursor_col = cur_col_q;

endmodule
